// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer.
// States, opcodes, strobe encodings and the decoded-instruction bundle.
package ctrl_pkg;

  localparam logic [3:0] S_IF      = 4'b0000;
  localparam logic [3:0] S_ID      = 4'b0001;
  localparam logic [3:0] S_EXE_MEM = 4'b0010;
  localparam logic [3:0] S_MEM     = 4'b0011;
  localparam logic [3:0] S_WB_LD   = 4'b0100;
  localparam logic [3:0] S_EXE_BR  = 4'b0101;
  localparam logic [3:0] S_EXE_ALU = 4'b0110;
  localparam logic [3:0] S_WB_ALU  = 4'b0111;
  localparam logic [3:0] S_HALTED  = 4'b1000;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_SLT  = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] EXT_NONE = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_SIGN = 2'b10;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  localparam logic [1:0] RO_RA = 2'b00;
  localparam logic [1:0] RO_RT = 2'b01;
  localparam logic [1:0] RO_RD = 2'b10;

  typedef struct packed {
    logic add;
    logic sub;
    logic addi;
    logic or_op;
    logic and_op;
    logic ori;
    logic sll;
    logic move;
    logic slt;
    logic sw;
    logic lw;
    logic beq;
    logic j;
    logic jr;
    logic jal;
    logic halt;
  } instr_t;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: latched opcode to instruction one-hot.
// Non-zero upper opcode bits make the opcode undecodable.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] op,
  output instr_t              ins,
  output logic                illegal
);

  logic       hi_ok;
  logic [5:0] lo;

  assign hi_ok = (op >> 6) == '0;
  assign lo    = op[5:0];

  always_comb begin
    ins = '0;
    if (hi_ok) begin
      unique case (lo)
        OP_ADD:  ins.add    = 1'b1;
        OP_SUB:  ins.sub    = 1'b1;
        OP_ADDI: ins.addi   = 1'b1;
        OP_OR:   ins.or_op  = 1'b1;
        OP_AND:  ins.and_op = 1'b1;
        OP_ORI:  ins.ori    = 1'b1;
        OP_SLL:  ins.sll    = 1'b1;
        OP_MOVE: ins.move   = 1'b1;
        OP_SLT:  ins.slt    = 1'b1;
        OP_SW:   ins.sw     = 1'b1;
        OP_LW:   ins.lw     = 1'b1;
        OP_BEQ:  ins.beq    = 1'b1;
        OP_J:    ins.j      = 1'b1;
        OP_JR:   ins.jr     = 1'b1;
        OP_JAL:  ins.jal    = 1'b1;
        OP_HALT: ins.halt   = 1'b1;
        default: ins = '0;
      endcase
    end
  end

  assign illegal = (ins == '0);

endmodule

// File: rtl/multicycle_ctrl_seq.sv
// Multi-cycle CPU control sequencer with memory handshakes and halt.
// Define CTRL_PERF_CNT_EN to add cycle / retired-instruction counters.
module multicycle_ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                resume,
  output logic [3:0]          state,
  output logic                pc_wre,
  output logic                ir_wre,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_rw,
  output logic                alu_src_b,
  output logic                alu_m2reg,
  output logic                reg_wre,
  output logic                wr_reg_data,
  output logic [1:0]          ext_sel,
  output logic [1:0]          pc_src,
  output logic [1:0]          reg_out,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                illegal_op
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    cyc_cnt,
  output logic [CNT_W-1:0]    instret_cnt
`endif
);

  if (ALUOP_W < 3 || OPCODE_W < 6 || CNT_W < 1) begin : g_bad_params
    $error("multicycle_ctrl_seq: parameter out of range");
  end

  logic [3:0]          state_q;
  logic [3:0]          state_n;
  logic [OPCODE_W-1:0] op_q;
  instr_t              ins;
  logic                illegal;
  logic                is_alu;
  logic                is_rtype;
  logic                is_mem;
  logic                is_jmp;
  logic                src_imm;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .op      (op_q),
    .ins     (ins),
    .illegal (illegal)
  );

  assign is_rtype = ins.add | ins.sub | ins.and_op | ins.or_op
                  | ins.move | ins.slt | ins.sll;
  assign is_alu   = is_rtype | ins.addi | ins.ori;
  assign is_mem   = ins.lw | ins.sw;
  assign is_jmp   = ins.j | ins.jr | ins.jal;
  assign src_imm  = ins.addi | ins.ori | ins.sw | ins.lw | ins.sll;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      op_q    <= '0;
    end else begin
      state_q <= state_n;
      if (ir_wre) op_q <= opcode;
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IF: if (imem_ready) state_n = S_ID;
      S_ID: begin
        unique case (1'b1)
          is_alu:   state_n = S_EXE_ALU;
          ins.beq:  state_n = S_EXE_BR;
          is_mem:   state_n = S_EXE_MEM;
          ins.halt: state_n = S_HALTED;
          default:  state_n = S_IF;
        endcase
      end
      S_EXE_MEM: state_n = S_MEM;
      S_MEM: begin
        if (dmem_ready) state_n = ins.lw ? S_WB_LD : S_IF;
      end
      S_EXE_ALU: state_n = S_WB_ALU;
      S_WB_ALU:  state_n = S_IF;
      S_WB_LD:   state_n = S_IF;
      S_EXE_BR:  state_n = S_IF;
      S_HALTED:  if (resume) state_n = S_IF;
      default:   state_n = S_IF;
    endcase
  end

  // Everything but wr_reg_data is forced low while reset is held.
  always_comb begin
    pc_wre      = 1'b0;
    ir_wre      = 1'b0;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_rw     = 1'b0;
    alu_src_b   = 1'b0;
    alu_m2reg   = 1'b0;
    reg_wre     = 1'b0;
    wr_reg_data = 1'b1;
    ext_sel     = EXT_NONE;
    pc_src      = PC_SEQ;
    reg_out     = RO_RA;
    alu_op      = '0;
    illegal_op  = 1'b0;
    if (!rst) begin
      ext_sel = {ins.addi | ins.sw | ins.lw | ins.beq, ins.ori};
      if (ins.addi | ins.ori | ins.lw) reg_out = RO_RT;
      else if (is_rtype)               reg_out = RO_RD;
      alu_op = ALUOP_W'({
        ins.ori | ins.and_op | ins.or_op | ins.sll,
        ins.and_op | ins.slt,
        ins.sub | ins.ori | ins.or_op | ins.beq
      });
      alu_src_b = src_imm & ((state_q == S_IF)
                | (state_q == S_EXE_MEM)
                | (state_q == S_EXE_BR)
                | (state_q == S_EXE_ALU));
      unique case (state_q)
        S_IF: begin
          imem_req = 1'b1;
          pc_wre   = imem_ready;
          ir_wre   = imem_ready;
        end
        S_ID: begin
          reg_wre     = ins.jal;
          wr_reg_data = ~ins.jal;
          illegal_op  = illegal;
          if (is_jmp) pc_src = {1'b1, ins.j | ins.jal};
        end
        S_EXE_BR: pc_src = {1'b0, ins.beq & zero};
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_rw  = ins.sw;
        end
        S_WB_LD: begin
          reg_wre   = 1'b1;
          alu_m2reg = 1'b1;
        end
        S_WB_ALU: reg_wre = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = state_q;

`ifdef CTRL_PERF_CNT_EN
  // Retirement is any return to IF except leaving HALTED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt     <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != S_HALTED) cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (state_n == S_IF && state_q != S_IF
          && state_q != S_HALTED)
        instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
